score_display: RTL and testbench
================================

SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 mclk  input  1  system clock; all state updates on rising edge.
REQ-002 _reset  input  1  asynchronous, active-low reset.
REQ-003 hcnt  input  9  horizontal pixel counter, 0..454, advances once per mclk pixel enable.
REQ-004 vcnt  input  9  vertical line counter, 0..261.
REQ-005 pix_en  input  1  pixel-clock enable; pipeline and snapshot advance only when high.
REQ-006 vblank  input  1  vertical blanking, high during blank.
REQ-007 s1a..s1d, s1e  input  1 each  player-1 score: BCD units (a=LSB), tens flag e.
REQ-008 s2a..s2d, s2e  input  1 each  player-2 score, same encoding.
REQ-009 stop_g  input  1  game-over flag, high when a player reached the winning score.
REQ-010 _attract  input  1  low during attract mode.
REQ-011 score_vid  output  1  score pixel video, high = lit.

Function
REQ-012 Scores SHALL be snapshot into internal registers on the pix_en cycle where vblank rises 0->1; display uses only the snapshot (no mid-frame tearing).
REQ-013 Score changes outside that edge SHALL NOT affect score_vid until the next vblank rising edge.
REQ-014 Digit cells: 16 px wide x 32 lines, vcnt 32..63; P1 tens hcnt 128..143, P1 units 160..175, P2 tens 288..303, P2 units 320..335.
REQ-015 Within a cell (col 0..15, row 0..31), segment hits: a rows 0-3; d rows 28-31; g rows 14-17; f cols 0-3 rows 0-15; e cols 0-3 rows 16-31; b cols 12-15 rows 0-15; c cols 12-15 rows 16-31.
REQ-016 Units digit SHALL decode BCD 0..9 to standard 7-segment patterns; codes 10..15 SHALL blank the cell.
REQ-017 Tens cell SHALL show "1" (segments b,c) when tens flag = 1, and be blank when 0 (leading-zero suppression).
REQ-018 Pipeline: stage 1 registers cell id, col, row, selected digit; stage 2 registers segment hit into score_vid; latency exactly 2 pix_en cycles from hcnt/vcnt to score_vid.
REQ-019 With pix_en low, all pipeline and snapshot registers SHALL hold.
REQ-020 score_vid SHALL be 0 whenever vblank is high at stage 1 or position lies outside all four cells.
REQ-021 Score display is active regardless of _attract (attract shows last snapshot).

Reset
REQ-022 While _reset low: snapshot registers = 0 (both scores 00), pipeline registers = 0, score_vid = 0, blink counter = 0.
REQ-023 Reset assertion mid-frame SHALL clear immediately (asynchronous); release SHALL be followed by normal operation from the next pix_en, first snapshot at the next vblank rise.

Configuration
REQ-024 Macro SCORE_BLINK_EN: when defined, a 5-bit frame counter increments at each vblank rising edge (wraps 31->0); while stop_g=1 and _attract=1, score_vid SHALL be forced 0 when counter bit 4 = 1 (16 frames on / 16 off).
REQ-025 Without SCORE_BLINK_EN: no frame counter is built; score_vid never gated by stop_g.

Structure
REQ-026 Cell geometry constants (cell x origins, y origin, width, height, segment thickness) SHALL live in the shared pong package/include.
REQ-027 One sub-module seg7_decode SHALL map 4-bit BCD plus blank to a 7-bit segment mask (a..g); instantiated once, fed from the stage-1 digit mux.

Verification
REQ-028 Reset, then score P1=0x00 P2=0x00, one frame -> units cells show "0", tens cells dark, score_vid=1 at hcnt=160 vcnt=32 two pix_en later.
REQ-029 P1 set to e=1,d..a=0101 mid-frame -> display unchanged until next vblank rise, then P1 shows "15".
REQ-030 P2 units = 1010 -> P2 units cell fully dark all frame.
REQ-031 pix_en toggled 1-0-1 around hcnt=320 -> score_vid holds during low cycle, latency counted in enabled cycles only.
REQ-032 SCORE_BLINK_EN defined, stop_g=1, _attract=1 for 64 frames -> score_vid lit frames 0-15, dark 16-31, lit 32-47, dark 48-63; with _attract=0 always lit.
REQ-033 _reset pulsed low at vcnt=40 -> score_vid=0 at once, snapshot reads 00 after next vblank with scores held at 0.

Source files
------------

// File: rtl/score_display_pkg.sv
// rtl/score_display_pkg.sv - score cell geometry, shared types and segment hit helper
package score_display_pkg;

  // Cell placement on the raster
  localparam int unsigned CELL_X_P1_TENS  = 128;
  localparam int unsigned CELL_X_P1_UNITS = 160;
  localparam int unsigned CELL_X_P2_TENS  = 288;
  localparam int unsigned CELL_X_P2_UNITS = 320;
  localparam int unsigned CELL_Y          = 32;

  // Cell size and stroke thickness
  localparam int unsigned CELL_W = 16;
  localparam int unsigned CELL_H = 32;
  localparam int unsigned SEG_T  = 4;

  typedef enum logic [2:0] {
    CELL_NONE     = 3'd0,
    CELL_P1_TENS  = 3'd1,
    CELL_P1_UNITS = 3'd2,
    CELL_P2_TENS  = 3'd3,
    CELL_P2_UNITS = 3'd4
  } cell_e;

  typedef struct packed {
    logic       tens;
    logic [3:0] units;
  } score_t;

  // Segment mask bit 0 = a ... bit 6 = g; true when (col,row) lies on a lit stroke
  function automatic logic seg_hit(input logic [6:0] seg, input logic [3:0] col,
                                   input logic [4:0] row);
    logic top_half;
    logic left;
    logic right;
    logic mid;
    top_half = row < 5'(CELL_H / 2);
    left     = col < 4'(SEG_T);
    right    = col >= 4'(CELL_W - SEG_T);
    mid      = (row >= 5'(CELL_H / 2 - SEG_T / 2)) && (row < 5'(CELL_H / 2 + SEG_T / 2));
    return (seg[0] & (row < 5'(SEG_T)))
         | (seg[1] & right & top_half)
         | (seg[2] & right & ~top_half)
         | (seg[3] & (row >= 5'(CELL_H - SEG_T)))
         | (seg[4] & left & ~top_half)
         | (seg[5] & left & top_half)
         | (seg[6] & mid);
  endfunction

endpackage

// File: rtl/score_display_if.sv
// rtl/score_display_if.sv - digit-to-segment decoder connection bundle
interface score_display_if;
  logic [3:0] digit;
  logic       blank;
  logic [6:0] seg;

  modport master (output digit, output blank, input seg);
  modport slave  (input digit, input blank, output seg);
endinterface

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - BCD digit plus blank to 7-segment mask (bit 0 = a .. bit 6 = g)
module seg7_decode (
  score_display_if.slave dec
);

  // Standard patterns for 0..9; codes 10..15 and blank give a dark cell
  always_comb begin
    dec.seg = 7'h00;
    if (!dec.blank) begin
      case (dec.digit)
        4'd0:    dec.seg = 7'h3F;
        4'd1:    dec.seg = 7'h06;
        4'd2:    dec.seg = 7'h5B;
        4'd3:    dec.seg = 7'h4F;
        4'd4:    dec.seg = 7'h66;
        4'd5:    dec.seg = 7'h6D;
        4'd6:    dec.seg = 7'h7D;
        4'd7:    dec.seg = 7'h07;
        4'd8:    dec.seg = 7'h7F;
        4'd9:    dec.seg = 7'h6F;
        default: dec.seg = 7'h00;
      endcase
    end
  end

endmodule

// File: rtl/score_display.sv
// rtl/score_display.sv - two-player score overlay; optional blink under macro SCORE_BLINK_EN
module score_display
  import score_display_pkg::*;
(
  input  logic       mclk,
  input  logic       _reset,
  input  logic [8:0] hcnt,
  input  logic [8:0] vcnt,
  input  logic       pix_en,
  input  logic       vblank,
  input  logic       s1a,
  input  logic       s1b,
  input  logic       s1c,
  input  logic       s1d,
  input  logic       s1e,
  input  logic       s2a,
  input  logic       s2b,
  input  logic       s2c,
  input  logic       s2d,
  input  logic       s2e,
  input  logic       stop_g,
  input  logic       _attract,
  output logic       score_vid
);

  score_t     p1_q, p1_d, p2_q, p2_d;
  logic       vblank_q, vblank_d;
  cell_e      cell_q, cell_d;
  logic [3:0] col_q, col_d;
  logic [4:0] row_q, row_d;
  logic [3:0] digit_q, digit_d;
  logic       digit_blank_q, digit_blank_d;
  logic       score_vid_q, score_vid_d;
  logic       vb_rise;
  logic       blink_off;
  logic       in_rows;
  logic [8:0] dy, dx_p1t, dx_p1u, dx_p2t, dx_p2u;

  score_display_if dec_if ();

  seg7_decode u_seg7 (.dec(dec_if));

  assign dec_if.digit = digit_q;
  assign dec_if.blank = digit_blank_q;
  assign vb_rise      = vblank & ~vblank_q;
  assign score_vid    = score_vid_q;

`ifdef SCORE_BLINK_EN
  logic [4:0] frame_q, frame_d;

  // Frame counter steps once per vblank rise, wrapping naturally at 5 bits
  always_comb begin
    frame_d = frame_q;
    if (vb_rise) frame_d = frame_q + 5'd1;
  end

  // Frame counter register, advancing only on enabled pixels
  always_ff @(posedge mclk or negedge _reset) begin
    if (!_reset)     frame_q <= '0;
    else if (pix_en) frame_q <= frame_d;
  end

  assign blink_off = stop_g & _attract & frame_q[4];
`else
  logic unused_blink_inputs;
  assign unused_blink_inputs = stop_g ^ _attract;
  assign blink_off = 1'b0;
`endif

  // Capture both scores only at the vblank rise so a frame never tears
  always_comb begin
    vblank_d = vblank;
    p1_d     = p1_q;
    p2_d     = p2_q;
    if (vb_rise) begin
      p1_d = '{tens: s1e, units: {s1d, s1c, s1b, s1a}};
      p2_d = '{tens: s2e, units: {s2d, s2c, s2b, s2a}};
    end
  end

  // Stage 1: locate the cell under the beam and pick the digit it shows
  always_comb begin
    dy            = vcnt - 9'(CELL_Y);
    dx_p1t        = hcnt - 9'(CELL_X_P1_TENS);
    dx_p1u        = hcnt - 9'(CELL_X_P1_UNITS);
    dx_p2t        = hcnt - 9'(CELL_X_P2_TENS);
    dx_p2u        = hcnt - 9'(CELL_X_P2_UNITS);
    in_rows       = dy < 9'(CELL_H);
    cell_d        = CELL_NONE;
    col_d         = '0;
    row_d         = dy[4:0];
    digit_d       = '0;
    digit_blank_d = 1'b1;
    if (in_rows) begin
      if (dx_p1t < 9'(CELL_W)) begin
        cell_d        = CELL_P1_TENS;
        col_d         = dx_p1t[3:0];
        digit_d       = 4'd1;
        digit_blank_d = ~p1_q.tens;
      end else if (dx_p1u < 9'(CELL_W)) begin
        cell_d        = CELL_P1_UNITS;
        col_d         = dx_p1u[3:0];
        digit_d       = p1_q.units;
        digit_blank_d = 1'b0;
      end else if (dx_p2t < 9'(CELL_W)) begin
        cell_d        = CELL_P2_TENS;
        col_d         = dx_p2t[3:0];
        digit_d       = 4'd1;
        digit_blank_d = ~p2_q.tens;
      end else if (dx_p2u < 9'(CELL_W)) begin
        cell_d        = CELL_P2_UNITS;
        col_d         = dx_p2u[3:0];
        digit_d       = p2_q.units;
        digit_blank_d = 1'b0;
      end
    end
    if (vblank || blink_off) digit_blank_d = 1'b1;
  end

  // Stage 2: light the pixel when it falls on a segment of the decoded digit
  always_comb begin
    score_vid_d = (cell_q != CELL_NONE) && seg_hit(dec_if.seg, col_q, row_q);
  end

  // Snapshot and pipeline registers, all frozen while pix_en is low
  always_ff @(posedge mclk or negedge _reset) begin
    if (!_reset) begin
      vblank_q      <= 1'b0;
      p1_q          <= '0;
      p2_q          <= '0;
      cell_q        <= CELL_NONE;
      col_q         <= '0;
      row_q         <= '0;
      digit_q       <= '0;
      digit_blank_q <= 1'b0;
      score_vid_q   <= 1'b0;
    end else if (pix_en) begin
      vblank_q      <= vblank_d;
      p1_q          <= p1_d;
      p2_q          <= p2_d;
      cell_q        <= cell_d;
      col_q         <= col_d;
      row_q         <= row_d;
      digit_q       <= digit_d;
      digit_blank_q <= digit_blank_d;
      score_vid_q   <= score_vid_d;
    end
  end

endmodule

// File: tb/tb_score_display.sv
// tb/tb_score_display.sv - directed and random checks of score_display against a pixel model
module tb_score_display;

  logic       mclk = 1'b0;
  logic       _reset;
  logic [8:0] hcnt, vcnt;
  logic       pix_en, vblank;
  logic       s1a, s1b, s1c, s1d, s1e;
  logic       s2a, s2b, s2c, s2d, s2e;
  logic       stop_g, _attract;
  logic       score_vid;

  int total = 0;
  int bad   = 0;

  // reference model state
  int   snap_p1u, snap_p1t, snap_p2u, snap_p2t;
  int   m_frame;
  bit   m_vbprev;
  logic m_s1, m_out;

  always #5 mclk = ~mclk;

  score_display dut (
    .mclk(mclk), ._reset(_reset), .hcnt(hcnt), .vcnt(vcnt), .pix_en(pix_en), .vblank(vblank),
    .s1a(s1a), .s1b(s1b), .s1c(s1c), .s1d(s1d), .s1e(s1e),
    .s2a(s2a), .s2b(s2b), .s2c(s2c), .s2d(s2d), .s2e(s2e),
    .stop_g(stop_g), ._attract(_attract), .score_vid(score_vid)
  );

  score_display_if tb_dec_if ();
  seg7_decode u_tb_dec (.dec(tb_dec_if));

  function automatic bit [6:0] ref_seg(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Expected pixel for a raster position, from the current model snapshot
  function automatic logic ref_pix(input int h, input int v, input bit vb, input bit sg,
                                   input bit att);
    int row, col;
    bit [6:0] m;
    if (vb) return 1'b0;
`ifdef SCORE_BLINK_EN
    if (sg && att && m_frame >= 16) return 1'b0;
`else
    if (sg && att && 1'b0) return 1'b0;
`endif
    if (v < 32 || v > 63) return 1'b0;
    row = v - 32;
    if (h >= 128 && h <= 143) begin
      col = h - 128; m = (snap_p1t != 0) ? ref_seg(1) : 7'h00;
    end else if (h >= 160 && h <= 175) begin
      col = h - 160; m = ref_seg(snap_p1u);
    end else if (h >= 288 && h <= 303) begin
      col = h - 288; m = (snap_p2t != 0) ? ref_seg(1) : 7'h00;
    end else if (h >= 320 && h <= 335) begin
      col = h - 320; m = ref_seg(snap_p2u);
    end else begin
      return 1'b0;
    end
    return (m[0] && row <= 3) || (m[1] && col >= 12 && row <= 15) ||
           (m[2] && col >= 12 && row >= 16) || (m[3] && row >= 28) ||
           (m[4] && col <= 3 && row >= 16) || (m[5] && col <= 3 && row <= 15) ||
           (m[6] && row >= 14 && row <= 17);
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    snap_p1u = 0; snap_p1t = 0; snap_p2u = 0; snap_p2t = 0;
    m_frame = 0; m_vbprev = 1'b0; m_s1 = 1'b0; m_out = 1'b0;
  endtask

  task automatic set_scores(input int p1u, input int p1t, input int p2u, input int p2t);
    {s1d, s1c, s1b, s1a} = p1u[3:0];
    s1e = p1t[0];
    {s2d, s2c, s2b, s2a} = p2u[3:0];
    s2e = p2t[0];
  endtask

  // One pixel slot: drive, clock, advance the model, compare with model
  task automatic step(input int h, input int v, input bit vb, input bit pe);
    @(negedge mclk);
    hcnt = 9'(h); vcnt = 9'(v); vblank = vb; pix_en = pe;
    @(posedge mclk);
    if (_reset && pix_en) begin
      m_out = m_s1;
      m_s1  = ref_pix(h, v, vb, stop_g, _attract);
      if (vb && !m_vbprev) begin
        snap_p1u = {s1d, s1c, s1b, s1a}; snap_p1t = s1e;
        snap_p2u = {s2d, s2c, s2b, s2a}; snap_p2t = s2e;
        m_frame  = (m_frame + 1) % 32;
      end
      m_vbprev = vb;
    end
    #1;
    check("model_pixel", {6'd0, score_vid}, {6'd0, m_out});
  endtask

  task automatic frame_edge();
    step(0, 0, 1'b1, 1'b1);
    step(0, 0, 1'b0, 1'b1);
  endtask

  // Drive one pixel and then one filler so the pixel reaches score_vid
  task automatic probe(input string tag, input int h, input int v, input logic exp);
    step(h, v, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b1);
    check(tag, {6'd0, score_vid}, {6'd0, exp});
  endtask

  initial begin
    int vb_r;
    logic exp_lit;
    _reset = 1'b0; hcnt = '0; vcnt = '0; pix_en = 1'b0; vblank = 1'b0;
    stop_g = 1'b0; _attract = 1'b1;
    set_scores(0, 0, 0, 0);
    model_reset();
    #1;
    check("reset_vid", {6'd0, score_vid}, 7'd0);
    repeat (2) @(negedge mclk);
    _reset = 1'b1;

    // both scores 00
    frame_edge();
    probe("p1u_zero_a", 160, 32, 1'b1);
    probe("p1t_dark", 136, 40, 1'b0);
    probe("p1u_zero_no_g", 168, 48, 1'b0);
    probe("p2u_zero_a", 328, 32, 1'b1);
    probe("p2t_dark", 296, 40, 1'b0);

    // P1 -> 15 mid-frame, visible only after the next vblank rise
    set_scores(5, 1, 0, 0);
    probe("p1u_old_b", 172, 40, 1'b1);
    probe("p1t_old_dark", 140, 40, 1'b0);
    frame_edge();
    probe("p1u_new_b_off", 172, 40, 1'b0);
    probe("p1u_new_f", 160, 40, 1'b1);
    probe("p1t_new_b", 140, 40, 1'b1);
    probe("p1t_new_f_off", 128, 40, 1'b0);

    // P2 units code 10 blanks the cell
    set_scores(5, 1, 10, 0);
    frame_edge();
    for (int i = 0; i < 12; i++)
      probe("p2u_blank", 320 + int'($urandom_range(0, 15)), 32 + int'($urandom_range(0, 31)), 1'b0);

    // pix_en gap around hcnt=320
    set_scores(5, 1, 8, 0);
    frame_edge();
    step(0, 0, 1'b0, 1'b1);
    step(320, 32, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b0);
    check("hold_low", {6'd0, score_vid}, 7'd0);
    step(0, 0, 1'b0, 1'b1);
    check("latency_enabled", {6'd0, score_vid}, 7'd1);
    step(0, 0, 1'b0, 1'b0);
    check("hold_high", {6'd0, score_vid}, 7'd1);
    step(0, 0, 1'b0, 1'b1);
    check("after_gap", {6'd0, score_vid}, 7'd0);

    // game over blink over 64 frames, then attract keeps it lit
    @(negedge mclk); _reset = 1'b0; model_reset();
    @(negedge mclk); _reset = 1'b1;
    set_scores(0, 0, 0, 0);
    stop_g = 1'b1; _attract = 1'b1;
    for (int f = 0; f < 64; f++) begin
`ifdef SCORE_BLINK_EN
      exp_lit = ((f / 16) % 2) == 0;
`else
      exp_lit = 1'b1;
`endif
      probe("blink_frame", 160, 32, exp_lit);
      step(0, 0, 1'b1, 1'b1);
    end
    _attract = 1'b0;
    for (int f = 0; f < 32; f++) begin
      probe("attract_lit", 160, 32, 1'b1);
      step(0, 0, 1'b1, 1'b1);
    end
    stop_g = 1'b0; _attract = 1'b1;

    // asynchronous reset in the middle of the digit rows
    set_scores(5, 1, 0, 0);
    frame_edge();
    probe("pre_reset_lit", 160, 40, 1'b1);
    #2 _reset = 1'b0;
    #1;
    check("async_reset", {6'd0, score_vid}, 7'd0);
    model_reset();
    @(negedge mclk); _reset = 1'b1;
    set_scores(0, 0, 0, 0);
    probe("post_reset_zero", 172, 40, 1'b1);
    frame_edge();
    probe("post_vb_zero_b", 172, 40, 1'b1);
    probe("post_vb_tens_dark", 140, 40, 1'b0);

    // random raster positions, score updates, enables and control flags
    vb_r = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 23) == 0) vb_r = 1 - vb_r;
      if ($urandom_range(0, 19) == 0)
        set_scores(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
      if ($urandom_range(0, 29) == 0) stop_g = ~stop_g;
      if ($urandom_range(0, 29) == 0) _attract = ~_attract;
      step(120 + int'($urandom_range(0, 229)), 26 + int'($urandom_range(0, 43)),
           vb_r[0], $urandom_range(0, 7) != 0);
    end

    // decoder exercised directly through its own interface instance
    for (int d = 0; d < 16; d++) begin
      for (int b = 0; b < 2; b++) begin
        tb_dec_if.digit = 4'(d);
        tb_dec_if.blank = b[0];
        #1;
        check("seg7_decode", tb_dec_if.seg, (b != 0) ? 7'h00 : ref_seg(d));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
